// File: rtl/cg_eval_arbiter_if.sv
// Requester/evaluator bus for the shared complex_gates arbiter.
// The slave side is the arbiter; the master side is the requesters plus the evaluator.
interface cg_eval_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    localparam int unsigned OP_W = 8;

    logic                    en;
    logic [N_REQ-1:0]        req;
    logic [OP_W*N_REQ-1:0]   req_x;
    logic [OP_W*N_REQ-1:0]   req_y;
    logic [N_REQ-1:0]        ack;
    logic                    res;
    logic [ID_W-1:0]         res_id;
    logic                    busy;
    logic [OP_W-1:0]         cg_x;
    logic [OP_W-1:0]         cg_y;
    logic                    cg_out;

    modport slave (
        input  en, req, req_x, req_y, cg_out,
        output ack, res, res_id, busy, cg_x, cg_y
    );

    modport master (
        output en, req, req_x, req_y, cg_out,
        input  ack, res, res_id, busy, cg_x, cg_y
    );
endinterface

// File: rtl/cg_eval_arbiter.sv
// Round-robin arbiter sharing one combinational complex_gates evaluator
// between N_REQ requesters: grant, one settle cycle, then a one-cycle ack.
module cg_eval_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    cg_eval_arbiter_if.slave  bus
);
    localparam int unsigned OP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gidx;

    logic            found_c;
    logic [ID_W-1:0] win_c;
    logic [ID_W-1:0] idx_c;
    logic [OP_W-1:0] sel_x_c;
    logic [OP_W-1:0] sel_y_c;
    logic [ID_W-1:0] ptr_next_c;

    // First active request searching upward from ptr, wrapping at N_REQ.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx_c = ID_W'((32'(ptr) + i) % N_REQ);
            if (!found_c && bus.req[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    // Operand mux for the winning lane.
    always_comb begin
        sel_x_c = '0;
        sel_y_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_c == ID_W'(i)) begin
                sel_x_c = bus.req_x[i*OP_W +: OP_W];
                sel_y_c = bus.req_y[i*OP_W +: OP_W];
            end
        end
    end

    assign ptr_next_c = (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gidx       <= '0;
            bus.ack    <= '0;
            bus.res    <= 1'b0;
            bus.res_id <= '0;
            bus.busy   <= 1'b0;
            bus.cg_x   <= '0;
            bus.cg_y   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en && found_c) begin
                        bus.cg_x <= sel_x_c;
                        bus.cg_y <= sel_y_c;
                        gidx     <= win_c;
                        bus.busy <= 1'b1;
                        state    <= EVAL;
                    end
                end
                // cg_x/cg_y have been stable for a full cycle; capture the result.
                EVAL: begin
                    bus.res    <= bus.cg_out;
                    bus.res_id <= gidx;
                    bus.ack    <= N_REQ'(1) << gidx;
                    ptr        <= ptr_next_c;
                    state      <= RESP;
                end
                RESP: begin
                    bus.ack  <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.ack  <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cg_eval_arbiter.sv
// Directed bench for cg_eval_arbiter with a behavioural complex_gates evaluator.
module tb_cg_eval_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    cg_eval_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    cg_eval_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic golden(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] a;
        a = x & y;
        return ((a[0] | a[1]) & (a[2] | a[3])) | ((a[4] | a[5]) & (a[6] | a[7]));
    endfunction

    assign bus.cg_out = golden(bus.cg_x, bus.cg_y);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic [7:0] x, input logic [7:0] y);
        bus.req_x[8*i +: 8] = x;
        bus.req_y[8*i +: 8] = y;
    endtask

    task automatic wait_ack(input int budget, output int waited, output logic got);
        got    = 1'b0;
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.ack != '0) begin
                got    = 1'b1;
                waited = i + 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bus.en    = 1'b1;
        bus.req   = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        rst_n     = 1'b0;
        repeat (3) tick();
        tests++; if (bus.ack !== 4'b0000) begin fails++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
        tests++; if (bus.res !== 1'b0) begin fails++; $display("FAIL reset_res got=%b exp=0", bus.res); end
        tests++; if (bus.res_id !== 2'd0) begin fails++; $display("FAIL reset_res_id got=%0d exp=0", bus.res_id); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests++; if (bus.cg_x !== 8'h00 || bus.cg_y !== 8'h00) begin
            fails++; $display("FAIL reset_cg got=%h/%h exp=00/00", bus.cg_x, bus.cg_y);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_lane(0, 8'hFF, 8'h0F);
        bus.req = 4'b0001;
        tick();
        tests++; if (bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
            fails++; $display("FAIL single_grant busy=%b ack=%b exp busy=1 ack=0000", bus.busy, bus.ack);
        end
        tests++; if (bus.cg_x !== 8'hFF || bus.cg_y !== 8'h0F) begin
            fails++; $display("FAIL single_cg got=%h/%h exp=ff/0f", bus.cg_x, bus.cg_y);
        end
        tick();
        tests++; if (bus.ack !== 4'b0001 || bus.res !== 1'b1 || bus.res_id !== 2'd0) begin
            fails++; $display("FAIL single_ack ack=%b res=%b id=%0d exp 0001/1/0", bus.ack, bus.res, bus.res_id);
        end
        bus.req = '0;
        tick();
        tests++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.res !== 1'b1) begin
            fails++; $display("FAIL single_done ack=%b busy=%b res=%b exp 0000/0/1", bus.ack, bus.busy, bus.res);
        end
    endtask

    task automatic test_req2();
        logic [7:0] tv [3] = '{8'h03, 8'h05, 8'hA0};
        logic       te [3] = '{1'b0, 1'b1, 1'b1};
        for (int v = 0; v < 3; v++) begin
            set_lane(2, tv[v], tv[v]);
            bus.req = 4'b0100;
            tick();
            tests++; if (bus.busy !== 1'b1 || bus.cg_x !== tv[v]) begin
                fails++; $display("FAIL req2_grant[%0d] busy=%b cg_x=%h exp 1/%h", v, bus.busy, bus.cg_x, tv[v]);
            end
            tick();
            tests++; if (bus.ack !== 4'b0100 || bus.res !== te[v] || bus.res_id !== 2'd2) begin
                fails++; $display("FAIL req2_ack[%0d] ack=%b res=%b id=%0d exp 0100/%b/2", v, bus.ack, bus.res, bus.res_id, te[v]);
            end
            bus.req = '0;
            tick();
        end
    endtask

    task automatic test_contention();
        logic exp_res [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int n    = 0;
        int last = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_lane(0, 8'hFF, 8'h0F);
        set_lane(1, 8'h03, 8'h03);
        set_lane(2, 8'h05, 8'h05);
        set_lane(3, 8'hA0, 8'hA0);
        bus.req = 4'b1111;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            tick();
            if (bus.ack != '0) begin
                tests++; if (bus.ack !== (4'b0001 << n) || bus.res_id !== 2'(n) || bus.res !== exp_res[n]) begin
                    fails++; $display("FAIL contention_ack[%0d] ack=%b id=%0d res=%b exp id=%0d res=%b", n, bus.ack, bus.res_id, bus.res, n, exp_res[n]);
                end
                if (n > 0) begin
                    tests++; if (c - last != 3) begin
                        fails++; $display("FAIL contention_spacing[%0d] got=%0d exp=3", n, c - last);
                    end
                end
                last    = c;
                n++;
                bus.req = bus.req & ~bus.ack;
            end
        end
        tests++; if (n != 4) begin fails++; $display("FAIL contention_count got=%0d exp=4", n); end
        tick();
        tests++; if (bus.busy !== 1'b0 || dut.ptr !== 2'd0) begin
            fails++; $display("FAIL contention_end busy=%b ptr=%0d exp 0/0", bus.busy, dut.ptr);
        end
    endtask

    task automatic test_fairness();
        int n    = 0;
        int last = 0;
        int expid;
        bus.req = 4'b1010;
        for (int c = 1; c <= 60 && n < 8; c++) begin
            tick();
            if (bus.ack != '0) begin
                expid = (n % 2 == 0) ? 1 : 3;
                tests++; if (bus.res_id !== 2'(expid) || bus.ack !== (4'b0001 << expid)) begin
                    fails++; $display("FAIL fairness_ack[%0d] id=%0d ack=%b exp id=%0d", n, bus.res_id, bus.ack, expid);
                end
                if (n > 0 && c - last != 3) begin
                    fails++; $display("FAIL fairness_spacing[%0d] got=%0d exp=3", n, c - last);
                end
                last = c;
                n++;
                if (n == 8) bus.req = '0;
            end
        end
        tests++; if (n != 8) begin fails++; $display("FAIL fairness_count got=%0d exp=8", n); end
        tick();
        tick();
    endtask

    task automatic test_enable();
        int acks = 0;
        set_lane(1, 8'h03, 8'h03);
        bus.en  = 1'b0;
        bus.req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.ack != '0 || bus.busy) acks++;
        end
        tests++; if (acks != 0) begin fails++; $display("FAIL enable_blocked got=%0d active cycles exp=0", acks); end
        bus.en = 1'b1;
        tick();
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL enable_grant busy=%b exp=1", bus.busy); end
        tick();
        tests++; if (bus.ack !== 4'b0010 || bus.res_id !== 2'd1 || bus.res !== 1'b0) begin
            fails++; $display("FAIL enable_ack ack=%b id=%0d res=%b exp 0010/1/0", bus.ack, bus.res_id, bus.res);
        end
        bus.req = '0;
        tick();
        bus.req = 4'b0010;
        tick();
        bus.en = 1'b0;
        tick();
        tests++; if (bus.ack !== 4'b0010) begin fails++; $display("FAIL enable_drop_ack got=%b exp=0010", bus.ack); end
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.ack != '0) acks++;
        end
        tests++; if (acks != 0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL enable_drop_nogrant acks=%0d busy=%b exp 0/0", acks, bus.busy);
        end
        bus.req = '0;
        bus.en  = 1'b1;
        tick();
    endtask

    task automatic test_reset_midop();
        int   waited;
        logic got;
        set_lane(1, 8'hA0, 8'hA0);
        set_lane(2, 8'h03, 8'h03);
        bus.req = 4'b0110;
        tick();
        tests++; if (bus.busy !== 1'b1 || bus.cg_x !== 8'h03) begin
            fails++; $display("FAIL midop_grant busy=%b cg_x=%h exp 1/03", bus.busy, bus.cg_x);
        end
        rst_n = 1'b0;
        tick();
        tests++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.res !== 1'b0 ||
                     bus.res_id !== 2'd0 || bus.cg_x !== 8'h00 || bus.cg_y !== 8'h00) begin
            fails++; $display("FAIL midop_reset ack=%b busy=%b res=%b id=%0d cg=%h/%h exp all 0",
                              bus.ack, bus.busy, bus.res, bus.res_id, bus.cg_x, bus.cg_y);
        end
        tick();
        tests++; if (bus.ack !== 4'b0000) begin fails++; $display("FAIL midop_noack got=%b exp=0000", bus.ack); end
        rst_n = 1'b1;
        wait_ack(8, waited, got);
        tests++; if (!got) begin
            fails++; $display("FAIL midop_regrant_timeout got=none exp=ack within 8 cycles");
        end else if (bus.ack !== 4'b0010 || bus.res_id !== 2'd1 || bus.res !== 1'b1 || bus.cg_x !== 8'hA0) begin
            fails++; $display("FAIL midop_regrant ack=%b id=%0d res=%b cg_x=%h exp 0010/1/1/a0",
                              bus.ack, bus.res_id, bus.res, bus.cg_x);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_req2();
        test_contention();
        test_fairness();
        test_enable();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test sequence");
        $fatal(1, "watchdog");
    end
endmodule
